// File: rtl/fft_bin_streamer.sv
// Frame sequencer for MEL_FBANK: streams spectrum bins with their aligned filterbank
// coefficients, then waits for the mel outputs or a drain timeout before reporting.
module fft_bin_streamer #(
   parameter int unsigned WIDTH         = 16,
   parameter int unsigned N_FFT         = 512,
   parameter int unsigned N_MEL         = 40,
   parameter int unsigned DRAIN_TIMEOUT = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               stall,
   output logic               rd_en,
   output logic [8:0]         rd_addr,
   input  logic [WIDTH-1:0]   spec_rd_data,
   input  logic [2*WIDTH-1:0] coef_weight_rd_data,
   input  logic [1:0]         coef_mac_rd_data,
   output logic               fft_bin_vld,
   output logic [WIDTH-1:0]   fft_bin,
   output logic [8:0]         fft_bin_idx,
   output logic [2*WIDTH-1:0] mel_fbank_weight,
   output logic [1:0]         mac_bits,
   input  logic               mel_spec_vld,
   output logic               busy,
   output logic               done,
   output logic               timeout_err,
   output logic [7:0]         frame_mel_cnt
);

   localparam int unsigned N_BINS = N_FFT / 2 + 1;
   localparam int unsigned TW     = $clog2(DRAIN_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t               state_q;
   logic [8:0]           bin_q;
   logic                 iss_q;
   logic [8:0]           addr_q;
   logic                 vld_q;
   logic [WIDTH-1:0]     bin_dat_q;
   logic [8:0]           idx_q;
   logic [2*WIDTH-1:0]   wt_q;
   logic [1:0]           mac_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 err_q;
   logic [7:0]           mel_cnt_q;
   logic [7:0]           mel_cnt_d;
   logic [TW-1:0]        to_q;
   logic                 mel_hit;
   logic                 last_rd;

   assign rd_en   = (state_q == S_STREAM) & ~stall & ~abort;
   assign rd_addr = bin_q;
   assign last_rd = rd_en && (bin_q == 9'(N_BINS - 1));
   assign mel_hit = mel_spec_vld && ((state_q == S_STREAM) || (state_q == S_DRAIN));

   always_comb begin
      mel_cnt_d = mel_cnt_q;
      if (mel_hit && (mel_cnt_q != 8'hFF)) mel_cnt_d = mel_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         bin_q     <= '0;
         iss_q     <= 1'b0;
         addr_q    <= '0;
         vld_q     <= 1'b0;
         bin_dat_q <= '0;
         idx_q     <= '0;
         wt_q      <= '0;
         mac_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         mel_cnt_q <= '0;
         to_q      <= '0;
      end else begin
         mel_cnt_q <= mel_cnt_d;
         done_q    <= 1'b0;
         // Two-stage alignment: issue flag/address follow the read, data registers a cycle later.
         iss_q     <= rd_en;
         if (rd_en) addr_q <= rd_addr;
         vld_q <= iss_q;
         if (iss_q) begin
            bin_dat_q <= spec_rd_data;
            wt_q      <= coef_weight_rd_data;
            mac_q     <= coef_mac_rd_data;
            idx_q     <= addr_q;
         end
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q   <= S_STREAM;
                  bin_q     <= '0;
                  mel_cnt_q <= '0;
                  err_q     <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            S_STREAM: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  iss_q   <= 1'b0;
                  vld_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (last_rd) begin
                  state_q <= S_DRAIN;
                  to_q    <= '0;
               end else if (rd_en) begin
                  bin_q <= bin_q + 9'd1;
               end
            end
            S_DRAIN: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  iss_q   <= 1'b0;
                  vld_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end else if ((mel_cnt_q >= 8'(N_MEL)) && !iss_q) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (to_q == TW'(DRAIN_TIMEOUT - 1)) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  to_q <= to_q + TW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign fft_bin_vld      = vld_q;
   assign fft_bin          = bin_dat_q;
   assign fft_bin_idx      = idx_q;
   assign mel_fbank_weight = wt_q;
   assign mac_bits         = mac_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign timeout_err      = err_q;
   assign frame_mel_cnt    = mel_cnt_q;

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Directed bench for fft_bin_streamer: SRAM/ROM models, bin scoreboard and frame-level checks.
module tb_fft_bin_streamer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        stall = 1'b0;
   logic        mel_spec_vld = 1'b0;
   logic        rd_en;
   logic [8:0]  rd_addr;
   logic [15:0] spec_rd_data = '0;
   logic [31:0] coef_weight_rd_data = '0;
   logic [1:0]  coef_mac_rd_data = '0;
   logic        fft_bin_vld;
   logic [15:0] fft_bin;
   logic [8:0]  fft_bin_idx;
   logic [31:0] mel_fbank_weight;
   logic [1:0]  mac_bits;
   logic        busy;
   logic        done;
   logic        timeout_err;
   logic [7:0]  frame_mel_cnt;

   fft_bin_streamer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
      .rd_en(rd_en), .rd_addr(rd_addr), .spec_rd_data(spec_rd_data),
      .coef_weight_rd_data(coef_weight_rd_data), .coef_mac_rd_data(coef_mac_rd_data),
      .fft_bin_vld(fft_bin_vld), .fft_bin(fft_bin), .fft_bin_idx(fft_bin_idx),
      .mel_fbank_weight(mel_fbank_weight), .mac_bits(mac_bits),
      .mel_spec_vld(mel_spec_vld), .busy(busy), .done(done),
      .timeout_err(timeout_err), .frame_mel_cnt(frame_mel_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] wfn(input logic [8:0] a);
      return {16'(a) * 16'd3 + 16'h1234, ~{7'd0, a}};
   endfunction

   function automatic logic [1:0] mfn(input logic [8:0] a);
      return a[1:0] ^ a[3:2];
   endfunction

   // Spectrum SRAM and coefficient ROM, one-cycle read latency
   always @(posedge clk) begin
      if (rd_en) begin
         spec_rd_data        <= 16'(rd_addr) + 16'h0100;
         coef_weight_rd_data <= wfn(rd_addr);
         coef_mac_rd_data    <= mfn(rd_addr);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   int sb[$];
   int vld_cnt, first_vld, last_vld, done_cnt, done_cyc;
   int issues, last_issue_cyc, stall_gaps, last_idx, last_mel;

   always @(negedge clk) begin
      if (rst_n) begin
         if (busy && stall && !abort && issues < 257) stall_gaps++;
         if (rd_en) begin
            issues++;
            if (rd_addr == 9'd256) last_issue_cyc = cyc;
         end
         if (fft_bin_vld) begin
            logic [63:0] exp_v;
            logic [8:0]  e;
            if (vld_cnt == 0) first_vld = cyc;
            last_vld = cyc;
            vld_cnt++;
            last_idx = int'(fft_bin_idx);
            if (sb.size() > 0) begin
               e = 9'(sb.pop_front());
               exp_v = {5'd0, e, 16'(e) + 16'h0100, wfn(e), mfn(e)};
            end else begin
               exp_v = '1;
            end
            chk("bin_fields", {5'd0, fft_bin_idx, fft_bin, mel_fbank_weight, mac_bits}, exp_v);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task tick;
      @(posedge clk);
      #1;
   endtask

   task automatic new_frame(output int s);
      vld_cnt = 0; first_vld = -1; last_vld = -1; done_cnt = 0; done_cyc = -1;
      issues = 0; last_issue_cyc = -1; stall_gaps = 0; last_idx = -1;
      sb.delete();
      for (int i = 0; i < 257; i++) sb.push_back(i);
      start = 1'b1;
      s = cyc;
      tick;
      start = 1'b0;
   endtask

   task automatic send_mels(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         mel_spec_vld = 1'b1;
         last_mel = cyc;
         tick;
         mel_spec_vld = 1'b0;
         repeat (gap - 1) tick;
      end
   endtask

   task automatic wait_done(input int budget);
      int t = 0;
      while (done_cnt == 0 && t < budget) begin
         tick;
         t++;
      end
      chk("done_seen", 64'(done_cnt != 0), 64'd1);
      repeat (3) tick;
   endtask

   task automatic wait_idx(input int idx, input int budget);
      int t = 0;
      while (!(fft_bin_vld && fft_bin_idx == 9'(idx)) && t < budget) begin
         tick;
         t++;
      end
      chk("reach_idx", 64'(fft_bin_idx), 64'(idx));
   endtask

   task automatic frame_check(input int s, input int mel);
      chk("vld_count", 64'(vld_cnt), 64'd257);
      chk("first_vld_lat", 64'(first_vld), 64'(s + 3));
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("mel_cnt", 64'(frame_mel_cnt), 64'(mel));
      chk("busy_idle", 64'(busy), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {31'd0, rd_en, rd_addr, fft_bin_vld, fft_bin_idx, mac_bits, busy, done,
                timeout_err, frame_mel_cnt}, 64'd0);
      chk(tag, {16'd0, fft_bin, mel_fbank_weight}, 64'd0);
   endtask

   initial begin
      int s;
      repeat (3) tick;
      chk_all_zero("reset_state");
      rst_n = 1'b1;
      tick;

      // Plain frame: 40 mel outputs returned while streaming
      new_frame(s);
      send_mels(40, 4);
      wait_done(600);
      frame_check(s, 40);
      chk("contiguous", 64'(last_vld - first_vld), 64'd256);
      chk("done_after_drain", 64'(done_cyc), 64'(last_issue_cyc + 3));
      chk("no_timeout", 64'(timeout_err), 64'd0);

      // Stall every third cycle
      new_frame(s);
      fork
         begin
            for (int i = 0; i < 450; i++) begin
               stall = (i % 3 == 2);
               tick;
            end
            stall = 1'b0;
         end
         send_mels(40, 4);
      join
      wait_done(200);
      frame_check(s, 40);
      chk("stall_seen", 64'(stall_gaps != 0), 64'd1);
      chk("gap_count", 64'(last_vld - first_vld + 1 - vld_cnt), 64'(stall_gaps));
      chk("stall_done", 64'(done_cyc), 64'(last_issue_cyc + 3));

      // Only 39 mel outputs: drain timeout
      new_frame(s);
      send_mels(39, 4);
      wait_done(700);
      frame_check(s, 39);
      chk("timeout_time", 64'(done_cyc), 64'(last_issue_cyc + 257));
      chk("timeout_err", 64'(timeout_err), 64'd1);
      send_mels(1, 2);
      chk("mel_idle_ignored", 64'(frame_mel_cnt), 64'd39);

      // Abort at index 100 (with stall asserted too)
      new_frame(s);
      chk("err_cleared", 64'(timeout_err), 64'd0);
      send_mels(10, 4);
      wait_idx(100, 200);
      abort = 1'b1;
      stall = 1'b1;
      tick;
      abort = 1'b0;
      stall = 1'b0;
      chk("abort_vld", 64'(fft_bin_vld), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_rd_en", 64'(rd_en), 64'd0);
      sb.delete();
      repeat (20) tick;
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_last_idx", 64'(last_idx), 64'd100);
      chk("abort_mel_hold", 64'(frame_mel_cnt), 64'd10);

      // Restream with start pulses in STREAM and DRAIN
      new_frame(s);
      repeat (50) tick;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int t = 0; t < 400 && issues < 257; t++) tick;
      chk("issues_done", 64'(issues), 64'd257);
      start = 1'b1;
      tick;
      start = 1'b0;
      send_mels(40, 2);
      wait_done(100);
      frame_check(s, 40);
      chk("done_after_mel", 64'(done_cyc), 64'(last_mel + 2));
      repeat (10) tick;
      chk("no_restream", 64'(vld_cnt), 64'd257);

      // Asynchronous reset mid-stream
      new_frame(s);
      wait_idx(50, 100);
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      repeat (3) tick;
      rst_n = 1'b1;
      tick;
      new_frame(s);
      send_mels(40, 4);
      wait_done(600);
      frame_check(s, 40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fft_bin_streamer.md
Name: fft_bin_streamer

Overview:
- Frame sequencer that drives the MEL_FBANK input interface.
- On a start pulse it reads N_FFT/2+1 spectrum bins from the spectrum SRAM and the matching filterbank coefficients (weight pair + mac_bits) from the coefficient ROM.
- Presents bin, index, weight and mac_bits cycle-aligned to MEL_FBANK.
- Counts returned mel_spec_vld pulses and signals frame completion, or a timeout error.

Parameters:
WIDTH, 16, bin and weight-half width (Q15)
N_FFT, 512, FFT size; N_BINS = N_FFT/2+1 = 257 (localparam)
N_MEL, 40, mel outputs expected per frame
DRAIN_TIMEOUT, 256, max cycles in DRAIN waiting for outstanding mel outputs

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  frame start pulse; sampled only in IDLE
abort  in  1  synchronous frame abort
stall  in  1  suppress read issue this cycle
rd_en  out  1  read strobe to spectrum SRAM and coefficient ROM
rd_addr  out  9  shared bin address, 0..N_BINS-1
spec_rd_data  in  WIDTH  spectrum SRAM data, valid the cycle after rd_en
coef_weight_rd_data  in  2*WIDTH  coefficient ROM weight pair, valid the cycle after rd_en
coef_mac_rd_data  in  2  coefficient ROM mac_bits, valid the cycle after rd_en
fft_bin_vld  out  1  bin valid to MEL_FBANK
fft_bin  out  WIDTH  bin value
fft_bin_idx  out  9  bin index
mel_fbank_weight  out  2*WIDTH  aligned weight pair
mac_bits  out  2  aligned mac_bits
mel_spec_vld  in  1  MEL_FBANK output strobe
busy  out  1  high in STREAM or DRAIN
done  out  1  one-cycle frame completion pulse
timeout_err  out  1  sticky error; cleared on next accepted start
frame_mel_cnt  out  8  mel_spec_vld count for the current frame, saturating at 255

Behaviour:
- Reset (async, rst_n low): state IDLE; every output 0, including rd_addr, fft_bin_idx, frame_mel_cnt, timeout_err.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE -> STREAM: on start=1. At the same edge: bin counter=0, frame_mel_cnt=0, timeout_err=0.
- start while not in IDLE: ignored.
- STREAM read issue:
  - rd_en = (state==STREAM) & !stall & !abort (combinational); rd_addr = bin counter.
  - Counter increments only on an issued read.
  - After the read of address N_BINS-1 issues -> DRAIN.
- Read latency: 1 cycle. A 1-bit issue flag plus the issued address are pipelined one stage.
- Output alignment: at the edge ending the data cycle, register fft_bin, mel_fbank_weight, mac_bits and fft_bin_idx (= pipelined address). fft_bin_vld = pipelined issue flag.
- Latency: first fft_bin_vld is high in the cycle starting 2 edges after the start-sampling edge.
- No stall: 257 contiguous vld cycles, idx 0..256.
- Stall: each stall cycle inserts exactly one vld=0 gap two cycles later. Index order is preserved; no bin is skipped or duplicated.
- Output fields hold their last values when vld=0.
- frame_mel_cnt increments on every mel_spec_vld while in STREAM or DRAIN (outputs may start before streaming ends). Saturates at 255.
- DRAIN: in-flight bin still presented. Timeout counter starts at 0 on entry.
  - frame_mel_cnt >= N_MEL and pipeline empty -> DONE.
  - Timeout counter reaching DRAIN_TIMEOUT -> timeout_err=1, -> DONE.
- DONE: done=1 for one cycle, -> IDLE. busy=0 in DONE and IDLE.
- abort in STREAM or DRAIN:
  - Next edge -> IDLE.
  - Pipelined issue flag cleared, so no further fft_bin_vld.
  - done not pulsed; frame_mel_cnt holds.
- abort in IDLE: no effect.
- Simultaneous abort and stall: abort wins.
- Simultaneous mel_spec_vld and the DRAIN->DONE transition: the count includes that pulse.
- mel_spec_vld in IDLE or DONE: ignored.

Test Plan:
- Reset, then start with no stall; SRAM[i]=i+0x100 -> vld high 257 consecutive cycles beginning 2 edges after start; idx 0..256 with fft_bin=idx+0x100; weight/mac_bits match ROM[idx]; model returns 40 mel_spec_vld -> one done pulse, frame_mel_cnt=40, timeout_err=0.
- stall asserted every 3rd cycle during STREAM -> still exactly 257 vld cycles; idx strictly increasing by 1; vld gaps equal stall count; done after 40th mel_spec_vld.
- Model returns only 39 mel_spec_vld -> done exactly DRAIN_TIMEOUT=256 cycles after DRAIN entry; timeout_err=1; frame_mel_cnt=39. Next start clears timeout_err.
- abort at idx 100 -> vld drops within 1 cycle; no idx >100 emitted; no done; busy=0; a new start restreams from idx 0.
- start pulsed again during STREAM and DRAIN -> ignored; idx sequence and done timing unchanged.
- rst_n low mid-STREAM (idx 50) -> all outputs 0 immediately (async); state IDLE; new start after reset produces idx 0..256 normally.
